f_to_int: RTL and testbench

- Pipelined IEEE-754 single-precision to signed 32-bit fixed-point converter.
- Performs the reverse of the team's float adder datapath: unpacks the exponent and hidden-bit significand, de-normalises by shifting, and applies two's-complement sign.
- Feeds integer/DSP consumers of f_adder results.
- Three register stages with valid/ready handshakes on input and output.

---
 rtl/f_to_int_if.sv | 28 ++
 rtl/f_to_int.sv | 142 ++++++++++++++
 tb/tb_f_to_int.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/f_to_int_if.sv
`default_nettype none
// ============================================================================
// Module   : f_to_int_if
// Desc     : Operand/result handshake bundle for the float32 to fixed-point
//            converter.
// Revision : 1.0 - initial release
// ============================================================================
interface f_to_int_if;
    logic        in_valid18;
    logic        in_ready18;
    logic [31:0] a18;
    logic        out_valid18;
    logic        out_ready18;
    logic [31:0] int18;
    logic        ovf18;
    logic        inexact18;

    modport master (
        output in_valid18, a18, out_ready18,
        input  in_ready18, out_valid18, int18, ovf18, inexact18
    );

    modport slave (
        input  in_valid18, a18, out_ready18,
        output in_ready18, out_valid18, int18, ovf18, inexact18
    );
endinterface
`default_nettype wire

// File: rtl/f_to_int.sv
`default_nettype none
// ============================================================================
// Module   : f_to_int
// Desc     : Three-stage IEEE-754 single to signed 32-bit fixed-point
//            converter (truncating, saturating) with valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module f_to_int #(
    parameter int FRAC_BITS = 0
) (
    input  wire       clk18,
    input  wire       rst_n18,
    f_to_int_if.slave bus
);
    // stage 1: unpack / classify
    logic              r_s1_valid;
    logic              r_s1_sign;
    logic              r_s1_zero;
    logic              r_s1_special;
    logic              r_s1_frac_zero;
    logic [23:0]       r_s1_sig;
    logic signed [9:0] r_s1_ee;

    // stage 2: de-normalised magnitude
    logic              r_s2_valid;
    logic              r_s2_sign;
    logic [31:0]       r_s2_mag;
    logic              r_s2_ovf;
    logic              r_s2_inexact;

    // stage 3: signed result
    logic              r_out_valid;
    logic [31:0]       r_int;
    logic              r_ovf;
    logic              r_inexact;

    logic              w_advance;
    logic [7:0]        w_exp;
    logic signed [9:0] w_ee;
    logic [4:0]        w_shr;
    logic [4:0]        w_shl;
    logic [31:0]       w_mag;
    logic              w_ovf;
    logic              w_inexact;
    logic [31:0]       w_int;

    assign w_advance = !r_out_valid || bus.out_ready18;

    assign w_exp = bus.a18[30:23];
    assign w_ee  = {2'b00, w_exp} - 10'd127 + 10'(FRAC_BITS);

    always_ff @(posedge clk18 or negedge rst_n18) begin
        if (!rst_n18) begin
            r_s1_valid     <= 1'b0;
            r_s1_sign      <= 1'b0;
            r_s1_zero      <= 1'b0;
            r_s1_special   <= 1'b0;
            r_s1_frac_zero <= 1'b0;
            r_s1_sig       <= '0;
            r_s1_ee        <= '0;
        end else if (w_advance) begin
            r_s1_valid <= bus.in_valid18;
            if (bus.in_valid18) begin
                r_s1_sign      <= bus.a18[31];
                r_s1_zero      <= (w_exp == 8'd0);
                r_s1_special   <= (w_exp == 8'hFF);
                r_s1_frac_zero <= (bus.a18[22:0] == 23'd0);
                r_s1_sig       <= {(w_exp != 8'd0), bus.a18[22:0]};
                r_s1_ee        <= w_ee;
            end
        end
    end

    // Only the low five bits matter: each shift is used solely in the range
    // where ee is 0..23 (right) or 24..31 (left).
    assign w_shr = 5'd23 - r_s1_ee[4:0];
    assign w_shl = r_s1_ee[4:0] - 5'd23;

    always_comb begin
        w_mag     = '0;
        w_ovf     = 1'b0;
        w_inexact = 1'b0;
        // ee == 31 fits only as exactly -2^31
        if (r_s1_special || (r_s1_ee > 10'sd31) ||
            ((r_s1_ee == 10'sd31) && !(r_s1_sign && r_s1_frac_zero))) begin
            w_ovf = 1'b1;
        end else if (r_s1_ee < 10'sd0) begin
            w_inexact = !r_s1_zero;
        end else if (r_s1_ee <= 10'sd23) begin
            w_mag     = {8'd0, (r_s1_sig >> w_shr)};
            w_inexact = |(r_s1_sig & ~(24'hFF_FFFF << w_shr));
        end else begin
            w_mag = {8'd0, r_s1_sig} << w_shl;
        end
    end

    always_ff @(posedge clk18 or negedge rst_n18) begin
        if (!rst_n18) begin
            r_s2_valid   <= 1'b0;
            r_s2_sign    <= 1'b0;
            r_s2_mag     <= '0;
            r_s2_ovf     <= 1'b0;
            r_s2_inexact <= 1'b0;
        end else if (w_advance) begin
            r_s2_valid   <= r_s1_valid;
            r_s2_sign    <= r_s1_sign;
            r_s2_mag     <= w_mag;
            r_s2_ovf     <= w_ovf;
            r_s2_inexact <= w_inexact;
        end
    end

    always_comb begin
        w_int = r_s2_mag;
        if (r_s2_ovf) begin
            w_int = r_s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (r_s2_sign) begin
            w_int = 32'd0 - r_s2_mag;
        end
    end

    always_ff @(posedge clk18 or negedge rst_n18) begin
        if (!rst_n18) begin
            r_out_valid <= 1'b0;
            r_int       <= '0;
            r_ovf       <= 1'b0;
            r_inexact   <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            r_int       <= w_int;
            r_ovf       <= r_s2_ovf;
            r_inexact   <= r_s2_inexact;
        end
    end

    assign bus.in_ready18  = w_advance;
    assign bus.out_valid18 = r_out_valid;
    assign bus.int18       = r_int;
    assign bus.ovf18       = r_ovf;
    assign bus.inexact18   = r_inexact;
endmodule
`default_nettype wire

// File: tb/tb_f_to_int.sv
`default_nettype none
// ============================================================================
// Module   : tb_f_to_int
// Desc     : Directed self-checking bench for f_to_int (FRAC_BITS 0 and 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_f_to_int;
    logic clk18 = 1'b0;
    logic rst_n18;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    always #5 clk18 = ~clk18;

    f_to_int_if b0 ();
    f_to_int_if b8 ();

    f_to_int #(.FRAC_BITS(0)) u_dut0 (.clk18(clk18), .rst_n18(rst_n18), .bus(b0.slave));
    f_to_int #(.FRAC_BITS(8)) u_dut8 (.clk18(clk18), .rst_n18(rst_n18), .bus(b8.slave));

    // Drives one operand, waits for its result; returns the result and the
    // number of clocks from acceptance to out_valid.
    task automatic convert(input bit f8, input logic [31:0] a,
                           output logic [31:0] r, output logic ov,
                           output logic ix, output int lat);
        @(negedge clk18);
        if (f8) begin b8.a18 = a; b8.in_valid18 = 1'b1; end
        else    begin b0.a18 = a; b0.in_valid18 = 1'b1; end
        @(posedge clk18);
        @(negedge clk18);
        b0.in_valid18 = 1'b0;
        b8.in_valid18 = 1'b0;
        lat = 1;
        while (!(f8 ? b8.out_valid18 : b0.out_valid18) && lat < 10) begin
            @(negedge clk18);
            lat++;
        end
        r  = f8 ? b8.int18     : b0.int18;
        ov = f8 ? b8.ovf18     : b0.ovf18;
        ix = f8 ? b8.inexact18 : b0.inexact18;
    endtask

    task automatic test_reset();
        rst_n18 = 1'b0;
        b0.in_valid18 = 1'b0; b0.a18 = '0; b0.out_ready18 = 1'b1;
        b8.in_valid18 = 1'b0; b8.a18 = '0; b8.out_ready18 = 1'b1;
        repeat (2) @(posedge clk18);
        @(negedge clk18);
        n_compared++;
        if (b0.out_valid18 !== 1'b0) begin n_mismatched++; $display("FAIL reset_out_valid got=%b want=0", b0.out_valid18); end
        n_compared++;
        if (b0.int18 !== 32'h0) begin n_mismatched++; $display("FAIL reset_int got=%h want=00000000", b0.int18); end
        n_compared++;
        if ({b0.ovf18, b0.inexact18} !== 2'b00) begin n_mismatched++; $display("FAIL reset_flags got=%b want=00", {b0.ovf18, b0.inexact18}); end
        n_compared++;
        if (b0.in_ready18 !== 1'b1) begin n_mismatched++; $display("FAIL reset_in_ready got=%b want=1", b0.in_ready18); end
        n_compared++;
        if (b8.out_valid18 !== 1'b0) begin n_mismatched++; $display("FAIL reset_out_valid_f8 got=%b want=0", b8.out_valid18); end
        rst_n18 = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] v_in [0:2];
        logic [31:0] v_int [0:2];
        logic [31:0] r;
        logic        ov, ix;
        int          lat;
        v_in  = '{32'h42F6_0000, 32'hC2F6_0000, 32'h3F80_0000};
        v_int = '{32'h0000_007B, 32'hFFFF_FF85, 32'h0000_0001};
        for (int i = 0; i < 3; i++) begin
            convert(1'b0, v_in[i], r, ov, ix, lat);
            n_compared++;
            if (r !== v_int[i]) begin n_mismatched++; $display("FAIL basic_int[%0d] got=%h want=%h", i, r, v_int[i]); end
            n_compared++;
            if ({ov, ix} !== 2'b00) begin n_mismatched++; $display("FAIL basic_flags[%0d] got=%b want=00", i, {ov, ix}); end
            n_compared++;
            if (lat !== 3) begin n_mismatched++; $display("FAIL basic_latency[%0d] got=%0d want=3", i, lat); end
        end
    endtask

    task automatic test_truncation();
        logic [31:0] v_in [0:3];
        logic [31:0] v_int [0:3];
        logic        v_ix [0:3];
        logic [31:0] r;
        logic        ov, ix;
        int          lat;
        v_in  = '{32'h3FC0_0000, 32'hBF00_0000, 32'h0040_0000, 32'hBFC0_0000};
        v_int = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        v_ix  = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            convert(1'b0, v_in[i], r, ov, ix, lat);
            n_compared++;
            if (r !== v_int[i]) begin n_mismatched++; $display("FAIL trunc_int[%0d] got=%h want=%h", i, r, v_int[i]); end
            n_compared++;
            if (ix !== v_ix[i]) begin n_mismatched++; $display("FAIL trunc_inexact[%0d] got=%b want=%b", i, ix, v_ix[i]); end
            n_compared++;
            if (ov !== 1'b0) begin n_mismatched++; $display("FAIL trunc_ovf[%0d] got=%b want=0", i, ov); end
        end
    endtask

    task automatic test_range();
        logic [31:0] v_in [0:4];
        logic [31:0] v_int [0:4];
        logic        v_ov [0:4];
        logic [31:0] r;
        logic        ov, ix;
        int          lat;
        v_in  = '{32'hCF00_0000, 32'h4F00_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h4EFF_FFFF};
        v_int = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FF80};
        v_ov  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            convert(1'b0, v_in[i], r, ov, ix, lat);
            n_compared++;
            if (r !== v_int[i]) begin n_mismatched++; $display("FAIL range_int[%0d] got=%h want=%h", i, r, v_int[i]); end
            n_compared++;
            if (ov !== v_ov[i]) begin n_mismatched++; $display("FAIL range_ovf[%0d] got=%b want=%b", i, ov, v_ov[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [0:3];
        logic [31:0] got [$];
        int          idx = 0;
        int          stall_left = 0;
        bit          stall_started = 1'b0;
        bit          acc = 1'b0;
        vals = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
            @(negedge clk18);
            if (cyc == 0) begin b0.a18 = vals[0]; b0.in_valid18 = 1'b1; end
            if (acc) begin
                idx++;
                if (idx < 4) b0.a18 = vals[idx];
                else         b0.in_valid18 = 1'b0;
            end
            if (!stall_started && b0.out_valid18) begin stall_started = 1'b1; stall_left = 5; end
            b0.out_ready18 = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                n_compared++;
                if (b0.in_ready18 !== 1'b0) begin n_mismatched++; $display("FAIL stall_in_ready got=%b want=0", b0.in_ready18); end
                n_compared++;
                if (b0.out_valid18 !== 1'b1) begin n_mismatched++; $display("FAIL stall_out_valid got=%b want=1", b0.out_valid18); end
                n_compared++;
                if (b0.int18 !== 32'd1) begin n_mismatched++; $display("FAIL stall_int_hold got=%h want=00000001", b0.int18); end
                stall_left--;
            end
            if (b0.out_valid18 && b0.out_ready18) got.push_back(b0.int18);
            acc = b0.in_valid18 && b0.in_ready18;
        end
        b0.in_valid18  = 1'b0;
        b0.out_ready18 = 1'b1;
        n_compared++;
        if (got.size() !== 4) begin n_mismatched++; $display("FAIL b2b_count got=%0d want=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                n_compared++;
                if (got[i] !== 32'(i + 1)) begin n_mismatched++; $display("FAIL b2b_order[%0d] got=%h want=%h", i, got[i], 32'(i + 1)); end
            end
        end
        // let the output register drain before the next scenario
        repeat (3) @(negedge clk18);
    endtask

    task automatic test_async_reset();
        logic [31:0] vals [0:2];
        logic [31:0] r;
        logic        ov, ix;
        int          lat;
        int          stale = 0;
        vals = '{32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000};
        @(negedge clk18);
        b0.out_ready18 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b0.a18 = vals[i];
            b0.in_valid18 = 1'b1;
            @(negedge clk18);
        end
        b0.in_valid18 = 1'b0;
        #2;
        n_compared++;
        if (b0.out_valid18 !== 1'b1) begin n_mismatched++; $display("FAIL pre_reset_valid got=%b want=1", b0.out_valid18); end
        rst_n18 = 1'b0;
        #1;
        n_compared++;
        if (b0.out_valid18 !== 1'b0) begin n_mismatched++; $display("FAIL async_reset_valid got=%b want=0", b0.out_valid18); end
        n_compared++;
        if (b0.int18 !== 32'h0) begin n_mismatched++; $display("FAIL async_reset_int got=%h want=00000000", b0.int18); end
        @(posedge clk18);
        @(negedge clk18);
        rst_n18 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk18);
            if (b0.out_valid18) stale++;
        end
        n_compared++;
        if (stale !== 0) begin n_mismatched++; $display("FAIL stale_after_reset got=%0d want=0", stale); end
        convert(1'b0, 32'h40A0_0000, r, ov, ix, lat);
        n_compared++;
        if (r !== 32'd5) begin n_mismatched++; $display("FAIL post_reset_int got=%h want=00000005", r); end
    endtask

    task automatic test_frac8();
        logic [31:0] v_in [0:3];
        logic [31:0] v_int [0:3];
        logic        v_ov [0:3];
        logic        v_ix [0:3];
        logic [31:0] r;
        logic        ov, ix;
        int          lat;
        v_in  = '{32'h3FC0_0000, 32'h3B80_0000, 32'h4B00_0000, 32'hBB00_0000};
        v_int = '{32'h0000_0180, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0000};
        v_ov  = '{1'b0, 1'b0, 1'b1, 1'b0};
        v_ix  = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            convert(1'b1, v_in[i], r, ov, ix, lat);
            n_compared++;
            if (r !== v_int[i]) begin n_mismatched++; $display("FAIL f8_int[%0d] got=%h want=%h", i, r, v_int[i]); end
            n_compared++;
            if ({ov, ix} !== {v_ov[i], v_ix[i]}) begin n_mismatched++; $display("FAIL f8_flags[%0d] got=%b want=%b", i, {ov, ix}, {v_ov[i], v_ix[i]}); end
            n_compared++;
            if (lat !== 3) begin n_mismatched++; $display("FAIL f8_latency[%0d] got=%0d want=3", i, lat); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_range();
        test_back_to_back();
        test_async_reset();
        test_frac8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
`default_nettype wire
